// File: rtl/wave_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wave_seq_ctrl
// Phase-accumulator sequencer for the sine/square/triangle ROM bank. Optional
// amplitude attenuation is enabled with the AMP_SCALE_EN macro.
// Revision : 1.0
// ============================================================================
module wave_seq_ctrl #(
    parameter int ACC_W   = 24,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 12,
    parameter int ROM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        wave_sel,
    input  logic [ACC_W-1:0]  fcw,
    input  logic              sample_tick,
    output logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] dout_sin,
    input  logic [DATA_W-1:0] dout_sq,
    input  logic [DATA_W-1:0] dout_tri,
`ifdef AMP_SCALE_EN
    input  logic [2:0]        amp_shift,
`endif
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              busy,
    output logic              cycle_done
);

    localparam logic [DATA_W-1:0] c_MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_act_fcw;
    logic [1:0]         r_act_sel;
    logic               w_active;
    logic               w_tick;
    logic               w_carry;
    logic [ACC_W-1:0]   w_sum;
    logic               w_wrap;

    logic [ROM_LAT:0]   r_pipe_vld;
    logic [1:0]         r_pipe_sel [0:ROM_LAT];
    logic [DATA_W-1:0]  w_raw;
    logic [DATA_W-1:0]  w_sample_nxt;

`ifdef AMP_SCALE_EN
    logic [2:0]                r_act_amp;
    logic [2:0]                r_pipe_amp [0:ROM_LAT];
    logic signed [DATA_W-1:0]  w_diff;
    logic signed [DATA_W-1:0]  w_shift;
`endif

    assign w_active       = (r_state != S_IDLE);
    assign w_tick         = w_active & sample_tick;
    assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_act_fcw};
    assign w_wrap         = w_tick & w_carry;
    assign busy           = w_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A zero tuning word never wraps, so stopping with it must exit at once.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (en) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!en) w_state_nxt = (r_act_fcw == '0) ? S_IDLE : S_STOP;
            end
            S_STOP: begin
                if (en)
                    w_state_nxt = S_RUN;
                else if ((r_act_fcw == '0) || w_wrap)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            addr1      <= '0;
            r_act_fcw  <= '0;
            r_act_sel  <= '0;
            cycle_done <= 1'b0;
`ifdef AMP_SCALE_EN
            r_act_amp  <= '0;
`endif
        end else begin
            cycle_done <= w_wrap;
            if (r_state == S_IDLE) begin
                r_acc <= '0;
                addr1 <= '0;
                if (en) begin
                    r_act_fcw <= fcw;
                    r_act_sel <= wave_sel;
`ifdef AMP_SCALE_EN
                    r_act_amp <= amp_shift;
`endif
                end
            end else begin
                if (w_tick) begin
                    addr1 <= r_acc[ACC_W-1 -: ADDR_W];
                    r_acc <= w_sum;
                end
                if (w_wrap) begin
                    r_act_fcw <= fcw;
                    r_act_sel <= wave_sel;
`ifdef AMP_SCALE_EN
                    r_act_amp <= amp_shift;
`endif
                end
                if (w_state_nxt == S_IDLE) r_acc <= '0;
            end
        end
    end

    always_comb begin
        w_raw = c_MIDSCALE;
        case (r_pipe_sel[ROM_LAT])
            2'd0:    w_raw = dout_sin;
            2'd1:    w_raw = dout_sq;
            2'd2:    w_raw = dout_tri;
            default: w_raw = c_MIDSCALE;
        endcase
`ifdef AMP_SCALE_EN
        // Subtracting/adding midscale modulo 2^DATA_W is an MSB flip.
        w_diff       = {~w_raw[DATA_W-1], w_raw[DATA_W-2:0]};
        w_shift      = w_diff >>> r_pipe_amp[ROM_LAT];
        w_sample_nxt = {~w_shift[DATA_W-1], w_shift[DATA_W-2:0]};
`else
        w_sample_nxt = w_raw;
`endif
    end

    // Tick and its selector travel together so the mux matches the ROM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld   <= '0;
            sample_valid <= 1'b0;
            sample       <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                r_pipe_sel[i] <= '0;
`ifdef AMP_SCALE_EN
                r_pipe_amp[i] <= '0;
`endif
            end
        end else begin
            r_pipe_vld    <= {r_pipe_vld[ROM_LAT-1:0], w_tick};
            r_pipe_sel[0] <= r_act_sel;
`ifdef AMP_SCALE_EN
            r_pipe_amp[0] <= r_act_amp;
`endif
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_pipe_sel[i] <= r_pipe_sel[i-1];
`ifdef AMP_SCALE_EN
                r_pipe_amp[i] <= r_pipe_amp[i-1];
`endif
            end
            sample_valid <= r_pipe_vld[ROM_LAT];
            if (r_pipe_vld[ROM_LAT]) sample <= w_sample_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wave_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_seq_ctrl
// Scoreboard bench for wave_seq_ctrl with a two-clock ROM model.
// Revision : 1.0
// ============================================================================
module tb_wave_seq_ctrl;

    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sample_tick = 1'b0;
    logic [1:0]  wave_sel = 2'd0;
    logic [23:0] fcw = 24'd0;
    logic [15:0] addr1;
    logic [11:0] dout_sin, dout_sq, dout_tri;
    logic [11:0] sample;
    logic        sample_valid, busy, cycle_done;
`ifdef AMP_SCALE_EN
    logic [2:0]  amp_shift = 3'd0;
`endif

    always #(PERIOD/2) clk = ~clk;

    wave_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .wave_sel     (wave_sel),
        .fcw          (fcw),
        .sample_tick  (sample_tick),
        .addr1        (addr1),
        .dout_sin     (dout_sin),
        .dout_sq      (dout_sq),
        .dout_tri     (dout_tri),
`ifdef AMP_SCALE_EN
        .amp_shift    (amp_shift),
`endif
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .cycle_done   (cycle_done)
    );

    function automatic logic [11:0] rom_sin(input logic [15:0] a);
        return a[15:4] ^ 12'h5A5;
    endfunction
    function automatic logic [11:0] rom_sq(input logic [15:0] a);
        return a[15] ? 12'hFFF : 12'h000;
    endfunction
    function automatic logic [11:0] rom_tri(input logic [15:0] a);
        return a[15] ? ~a[14:3] : a[14:3];
    endfunction

    // ROM bank: data settles two clocks after addr1 changes.
    logic [15:0] rom_a1 = 16'd0;
    logic [15:0] rom_a2 = 16'd0;
    always @(posedge clk) begin
        rom_a1 <= addr1;
        rom_a2 <= rom_a1;
    end
    assign dout_sin = rom_sin(rom_a2);
    assign dout_sq  = rom_sq(rom_a2);
    assign dout_tri = rom_tri(rom_a2);

    typedef struct {
        logic [11:0] val;
        longint      t;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int          m_state = 0;
    logic [23:0] m_acc   = 24'd0;
    logic [23:0] m_fcw   = 24'd0;
    logic [1:0]  m_sel   = 2'd0;
    logic [2:0]  m_amp   = 3'd0;
    logic [15:0] m_addr  = 16'd0;

    function automatic logic [11:0] exp_sample(input logic [15:0] a, input logic [1:0] s,
                                               input logic [2:0] sh);
        logic [11:0] raw;
        int d;
        case (s)
            2'd0:    raw = rom_sin(a);
            2'd1:    raw = rom_sq(a);
            2'd2:    raw = rom_tri(a);
            default: raw = 12'h800;
        endcase
        d = int'(raw) - 2048;
        d = d >>> sh;
        return 12'(d + 2048);
    endfunction

    task automatic latch_inputs();
        m_fcw = fcw;
        m_sel = wave_sel;
`ifdef AMP_SCALE_EN
        m_amp = amp_shift;
`endif
    endtask

    // Called at a negedge; applies inputs for one clock and checks the result.
    task automatic step(input logic t_en, input logic t_tick);
        logic [24:0] sum;
        logic        wrap;
        int          nxt;
        en = t_en;
        sample_tick = t_tick;
        @(posedge clk);
        wrap = 1'b0;
        if (m_state != 0 && t_tick) begin
            m_addr = m_acc[23:8];
            sbq.push_back('{exp_sample(m_addr, m_sel, m_amp), longint'($time) + 3*PERIOD + PERIOD/2});
            sum    = {1'b0, m_acc} + {1'b0, m_fcw};
            wrap   = sum[24];
            m_acc  = sum[23:0];
        end
        nxt = m_state;
        case (m_state)
            0:       if (t_en) nxt = 1;
            1:       if (!t_en) nxt = (m_fcw == 24'd0) ? 0 : 2;
            default: if (t_en) nxt = 1;
                     else if (m_fcw == 24'd0 || wrap) nxt = 0;
        endcase
        if (m_state == 0) begin
            m_acc  = 24'd0;
            m_addr = 16'd0;
            if (t_en) latch_inputs();
        end else begin
            if (wrap) latch_inputs();
            if (nxt == 0) m_acc = 24'd0;
        end
        m_state = nxt;
        #1;
        check("addr1", 32'(addr1), 32'(m_addr));
        check("cycle_done", 32'(cycle_done), 32'(wrap));
        check("busy", 32'(busy), 32'(m_state != 0));
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("sample", 32'(sample), 32'(e.val));
                    check("valid_time", 32'($time), 32'(e.t));
                end
            end else if (sbq.size() != 0 && longint'($time) > sbq[0].t) begin
                check("valid_missing", 32'd0, 32'd1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_addr1", 32'(addr1), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cycle_done", 32'(cycle_done), 32'd0);
        rst_n = 1'b1;

        // Sine, step 0x1000; tick on the enable edge is ignored.
        fcw = 24'h100000;
        wave_sel = 2'd0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1);

        // Mid-cycle change takes effect only at the wrap.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        wave_sel = 2'd2;
        fcw = 24'h080000;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
        wave_sel = 2'd1;
        fcw = 24'h100000;
        step(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1);

        // Stop request mid-cycle finishes the cycle first.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        begin
            int n = 0;
            while (m_state != 0 && n < 40) begin
                step(1'b0, 1'b1);
                n++;
            end
            check("stop_bound", 32'(m_state), 32'd0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

        // Silence, then a zero tuning word with en low exits immediately.
        wave_sel = 2'd3;
        fcw = 24'h100000;
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        fcw = 24'd0;
        for (int i = 0; i < 13; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

        // Asynchronous reset with reads in flight.
        wave_sel = 2'd0;
        fcw = 24'h100000;
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_addr1", 32'(addr1), 32'd0);
        check("arst_sample", 32'(sample), 32'd0);
        check("arst_valid", 32'(sample_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cycle_done", 32'(cycle_done), 32'd0);
        sbq.delete();
        m_state = 0;
        m_acc = 24'd0;
        m_addr = 16'd0;
        en = 1'b0;
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

`ifdef AMP_SCALE_EN
        // Square wave attenuated by 2, then by 1 after the wrap.
        wave_sel = 2'd1;
        fcw = 24'h100000;
        amp_shift = 3'd2;
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        amp_shift = 3'd1;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
        check("amp_model_a", 32'(exp_sample(16'h8000, 2'd1, 3'd2)), 32'h9FF);
        check("amp_model_b", 32'(exp_sample(16'h0000, 2'd1, 3'd1)), 32'h400);
        begin
            int n = 0;
            while (m_state != 0 && n < 40) begin
                step(1'b0, 1'b1);
                n++;
            end
            check("amp_stop_bound", 32'(m_state), 32'd0);
        end
`endif

        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        check("sbq_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
